bcd_counter_n: RTL and testbench



---
 rtl/bcd_counter_n.sv | 121 ++++++++++++
 tb/tb_bcd_counter_n.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bcd_counter_n.sv
// Parametrised multi-digit BCD up/down counter with validated parallel load,
// registered wrap/load-error pulses and a combinational terminal count.
// Build option: define BCD_COUNTER_N_SAT_EN for saturating (non-wrapping) mode.

module bcd_counter_n_digit #(
    parameter logic [3:0] TOP = 4'd9
) (
    input  logic [3:0] cnt,
    input  logic       up,
    input  logic       step,
    input  logic [3:0] ld_val,
    output logic [3:0] nxt,
    output logic       at_top,
    output logic       at_zero,
    output logic       ld_ok
);
    assign at_top  = (cnt == TOP);
    assign at_zero = (cnt == 4'd0);
    assign ld_ok   = (ld_val <= TOP);

    always_comb begin
        nxt = cnt;
        if (step) begin
            if (up) nxt = at_top  ? 4'd0 : cnt + 4'd1;
            else    nxt = at_zero ? TOP  : cnt - 4'd1;
        end
    end
endmodule

module bcd_counter_n #(
    parameter int DIGITS  = 4,
    parameter int MSD_MAX = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ena_i,
    input  logic                  updown_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    output logic [4*DIGITS-1:0]   cnt_o,
    output logic                  tc_o,
    output logic                  wrap_o,
    output logic                  load_err_o
);
    logic [DIGITS-1:0][3:0] cnt_q, cnt_nxt, ld_d;
    logic [DIGITS-1:0]      at_top, at_zero, ld_ok, lim, step;
    logic                   wrap_evt, ld_valid, err_q;

    assign ld_d = load_val_i;

    // Digit g steps when every lower digit sits at its direction limit.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        localparam logic [3:0] TOP = (g == DIGITS - 1) ? 4'(MSD_MAX) : 4'd9;

        if (g == 0) begin : g_lsd
            assign step[g] = 1'b1;
        end else begin : g_upper
            assign step[g] = &lim[g-1:0];
        end

        assign lim[g] = updown_i ? at_top[g] : at_zero[g];

        bcd_counter_n_digit #(.TOP(TOP)) u_digit (
            .cnt     (cnt_q[g]),
            .up      (updown_i),
            .step    (step[g]),
            .ld_val  (ld_d[g]),
            .nxt     (cnt_nxt[g]),
            .at_top  (at_top[g]),
            .at_zero (at_zero[g]),
            .ld_ok   (ld_ok[g])
        );
    end

    assign wrap_evt = &lim;
    assign ld_valid = &ld_ok;
    assign tc_o     = ena_i & ((updown_i & (&at_top)) | (!updown_i & (&at_zero)));
    assign cnt_o    = cnt_q;

`ifdef BCD_COUNTER_N_SAT_EN
    assign wrap_o = 1'b0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (load_i) begin
                if (ld_valid) cnt_q <= ld_d;
                else          err_q <= 1'b1;
            end else if (ena_i && !wrap_evt) begin
                cnt_q <= cnt_nxt;
            end
        end
    end
`else
    logic wrap_q;
    assign wrap_o = wrap_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            if (load_i) begin
                if (ld_valid) cnt_q <= ld_d;
                else          err_q <= 1'b1;
            end else if (ena_i) begin
                cnt_q  <= cnt_nxt;
                wrap_q <= wrap_evt;
            end
        end
    end
`endif

    assign load_err_o = err_q;
endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n at DIGITS=2, MSD_MAX=5 (range 00..59).
module tb_bcd_counter_n;
`ifdef BCD_COUNTER_N_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, ena, up, load;
    logic [7:0] load_val;
    logic [7:0] cnt;
    logic       tc, wrap, lerr;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_counter_n #(.DIGITS(2), .MSD_MAX(5)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ena_i      (ena),
        .updown_i   (up),
        .load_i     (load),
        .load_val_i (load_val),
        .cnt_o      (cnt),
        .tc_o       (tc),
        .wrap_o     (wrap),
        .load_err_o (lerr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, ena, up, load;
        logic [7:0] val;
        logic       tc;      // expected before the edge
        logic [7:0] cnt;     // expected after the edge
        logic       wrap, err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Apply inputs at the falling edge, check tc, then check registered outputs after the rise.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst_n = v.rst_n; ena = v.ena; up = v.up; load = v.load; load_val = v.val;
        #1 chk({tag, " tc"}, {7'd0, tc}, {7'd0, v.tc});
        @(posedge clk);
        #1;
        chk({tag, " cnt"},  cnt, v.cnt);
        chk({tag, " wrap"}, {7'd0, wrap}, {7'd0, v.wrap});
        chk({tag, " err"},  {7'd0, lerr}, {7'd0, v.err});
    endtask

    function automatic vec_t mk(logic r, logic e, logic u, logic l, logic [7:0] val,
                                logic t, logic [7:0] c, logic w, logic er);
        vec_t v;
        v.rst_n = r; v.ena = e; v.up = u; v.load = l; v.val = val;
        v.tc = t; v.cnt = c; v.wrap = w; v.err = er;
        return v;
    endfunction

    initial begin
        int m;
        rst_n = 1'b0; ena = 1'b0; up = 1'b0; load = 1'b0; load_val = 8'h00;

        //                  rst ena up ld val    tc  cnt    wrap err
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 8'h37, 0, 8'h37, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h42, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 8'h42, 0, 8'h42, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 8'h6A, 0, 8'h42, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h42, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 8'h60, 0, 8'h42, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 8'hA0, 0, 8'h42, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 8'h1A, 0, 8'h42, 0, 1));
        vecs.push_back(mk(1, 1, 1, 1, 8'h19, 0, 8'h19, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 8'h00, 0, 8'h20, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 0, 8'h19, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 8'h00, 0, 8'h20, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, i[0], 0, 8'h00, 0, 8'h20, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0));
        if (SAT) begin
            vecs.push_back(mk(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0));
            vecs.push_back(mk(1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0));
        end else begin
            vecs.push_back(mk(1, 1, 0, 0, 8'h00, 1, 8'h59, 1, 0));
            vecs.push_back(mk(1, 1, 0, 0, 8'h00, 0, 8'h58, 0, 0));
        end
        vecs.push_back(mk(1, 0, 0, 1, 8'h10, 0, 8'h10, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 0, 8'h09, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 8'h00, 0, 8'h10, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 8'h59, 0, 8'h59, 0, 0));
        if (SAT) vecs.push_back(mk(1, 1, 1, 0, 8'h00, 1, 8'h59, 0, 0));
        else     vecs.push_back(mk(1, 1, 1, 0, 8'h00, 1, 8'h00, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 8'h00, 0, SAT ? 8'h59 : 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 8'h59, 0, 8'h59, 0, 0));
        // Load at MAX with ena=1, up=1: load wins, tc still flags the limit.
        vecs.push_back(mk(1, 1, 1, 1, 8'h31, 1, 8'h31, 0, 0));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Reset takes effect only at the edge.
        apply(mk(1, 0, 0, 1, 8'h37, 0, 8'h37, 0, 0), "rst_pre_load");
        @(negedge clk);
        rst_n = 1'b0; ena = 1'b1; up = 1'b1; load = 1'b0;
        #2 chk("rst_no_async cnt", cnt, 8'h37);
        @(posedge clk);
        #1 chk("rst_edge cnt", cnt, 8'h00);
        chk("rst_edge wrap", {7'd0, wrap}, 8'h00);

        // Full up run from 00 against an integer model, then 3 extra steps past MAX.
        m = 0;
        for (int c = 0; c < 63; c++) begin
            vec_t v;
            int nx;
            logic w;
            w  = !SAT && (m == 59);
            nx = (m == 59) ? (SAT ? 59 : 0) : m + 1;
            v  = mk(1, 1, 1, 0, 8'h00, (m == 59), bcd(nx), w, 0);
            apply(v, $sformatf("uprun%0d", c));
            m = nx;
        end

        // Down run across the 10->09 borrow and 00 limit.
        apply(mk(1, 0, 0, 1, 8'h11, 0, 8'h11, 0, 0), "dn_load");
        m = 11;
        for (int c = 0; c < 14; c++) begin
            vec_t v;
            int nx;
            logic w;
            w  = !SAT && (m == 0);
            nx = (m == 0) ? (SAT ? 0 : 59) : m - 1;
            v  = mk(1, 1, 0, 0, 8'h00, (m == 0), bcd(nx), w, 0);
            apply(v, $sformatf("dnrun%0d", c));
            m = nx;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
